// File: rtl/unpackhint.sv
// rtl/unpackhint.sv - hint field unpacker for signature verify
// Buffers the packed hint bytes, validates counts/padding, then expands to per-coefficient hint bits.
module unpackhint #(
  parameter int OUTPUT_W = 4,
  parameter int W        = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          sec_lvl,
  input  logic [W-1:0]        hint_i,
  input  logic                hint_valid_i,
  output logic                hint_ready_i,
  output logic [OUTPUT_W-1:0] h_o,
  output logic                h_valid_o,
  input  logic                h_ready_o,
  output logic                done_o,
  output logic                reject_hint
);

  localparam int MAXW = 11;
  localparam int NB   = MAXW * 8;

  typedef enum logic [1:0] {S_LOAD, S_CHECK, S_EMIT, S_DONE} state_t;

  state_t              state, state_n;
  logic [NB*8-1:0]     buf_q;
  logic [3:0]          ctr;
  logic [2:0]          poly;
  logic [5:0]          c;
  logic [6:0]          ptr;
  logic                reject_q, done_q;

  logic [3:0]          k_num, nwords;
  logic [7:0]          omega;
  logic                bad_check;
  logic [7:0]          prev_cnt, cur_cnt, last_cnt, cnt_poly, idx;
  logic [2:0]          m;
  logic [OUTPUT_W-1:0] hb;
  logic [6:0]          ptr_next;
  logic                load_fire, emit_fire, set_reject, set_done;

  // Bytes past the buffer read as zero so stray indices never reach X.
  function automatic logic [7:0] byte_at(input logic [NB*8-1:0] v, input logic [7:0] n);
    return (n < 8'd88) ? v[{n[6:0], 3'b000} +: 8] : 8'd0;
  endfunction

  always_comb begin
    k_num  = 4'd8;
    omega  = 8'd75;
    nwords = 4'd11;
    case (sec_lvl)
      3'd2: begin k_num = 4'd4; omega = 8'd80; nwords = 4'd11; end
      3'd3: begin k_num = 4'd6; omega = 8'd55; nwords = 4'd8;  end
      default: ;
    endcase
  end

  always_comb begin
    bad_check = 1'b0;
    prev_cnt  = 8'd0;
    cur_cnt   = 8'd0;
    for (int k = 0; k < 8; k++) begin
      if (k < int'(k_num)) begin
        cur_cnt = byte_at(buf_q, omega + 8'(k));
        if (cur_cnt > omega || cur_cnt < prev_cnt) bad_check = 1'b1;
        prev_cnt = cur_cnt;
      end
    end
    last_cnt = byte_at(buf_q, omega + {4'b0, k_num} - 8'd1);
    for (int p = 0; p < 80; p++) begin
      if (8'(p) >= last_cnt && 8'(p) < omega && byte_at(buf_q, 8'(p)) != 8'd0) bad_check = 1'b1;
    end
  end

  // Indices of a poly must appear in strictly increasing order, so a sequential match suffices.
  always_comb begin
    cnt_poly = byte_at(buf_q, omega + {5'b0, poly});
    m        = 3'd0;
    hb       = '0;
    idx      = 8'd0;
    for (int j = 0; j < OUTPUT_W; j++) begin
      idx = {1'b0, ptr} + {5'b0, m};
      if (idx < cnt_poly && byte_at(buf_q, idx) == {c, 2'(j)}) begin
        hb[j] = 1'b1;
        m     = m + 3'd1;
      end
    end
    ptr_next = ptr + {4'b0, m};
  end

  always_comb begin
    state_n    = state;
    load_fire  = 1'b0;
    emit_fire  = 1'b0;
    set_reject = 1'b0;
    set_done   = 1'b0;
    case (state)
      S_LOAD: begin
        if (hint_valid_i && !reject_q) begin
          load_fire = 1'b1;
          if (ctr == nwords - 4'd1) state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad_check) begin
          set_reject = 1'b1;
          state_n    = S_DONE;
        end else begin
          state_n = S_EMIT;
        end
      end
      S_EMIT: begin
        emit_fire = h_ready_o && !reject_q;
        if (emit_fire && c == 6'd63) begin
          if ({1'b0, ptr_next} != cnt_poly) begin
            set_reject = 1'b1;
            state_n    = S_DONE;
          end else if (poly == 3'(k_num - 4'd1)) begin
            set_done = 1'b1;
            state_n  = S_DONE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_LOAD;
      buf_q    <= '0;
      ctr      <= 4'd0;
      poly     <= 3'd0;
      c        <= 6'd0;
      ptr      <= 7'd0;
      reject_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= set_done;
      if (set_reject) reject_q <= 1'b1;
      if (load_fire) begin
        buf_q[{ctr, 6'b000000} +: W] <= hint_i;
        ctr <= ctr + 4'd1;
      end
      if (state == S_CHECK) begin
        poly <= 3'd0;
        c    <= 6'd0;
        ptr  <= 7'd0;
      end
      if (emit_fire) begin
        ptr <= ptr_next;
        c   <= c + 6'd1;
        if (c == 6'd63) poly <= poly + 3'd1;
      end
    end
  end

  assign hint_ready_i = (state == S_LOAD) && !reject_q;
  assign h_valid_o    = (state == S_EMIT) && !reject_q;
  assign h_o          = h_valid_o ? hb : '0;
  assign done_o       = done_q && !reject_q;
  assign reject_hint  = reject_q;

endmodule

// File: tb/tb_unpackhint.sv
// tb/tb_unpackhint.sv - directed self-checking bench for unpackhint
module tb_unpackhint;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sec_lvl;
  logic [63:0] hint_i;
  logic        hint_valid_i;
  logic        hint_ready_i;
  logic [3:0]  h_o;
  logic        h_valid_o;
  logic        h_ready_o;
  logic        done_o;
  logic        reject_hint;

  int checks = 0;
  int errors = 0;

  logic [7:0] bb [0:87];
  logic [3:0] hq [$];
  int         done_cnt;
  int         valid_cnt;
  bit         rej_seen;

  always #5 clk = ~clk;

  unpackhint #(.OUTPUT_W(4), .W(64)) dut (
    .clk(clk), .rst(rst), .sec_lvl(sec_lvl),
    .hint_i(hint_i), .hint_valid_i(hint_valid_i), .hint_ready_i(hint_ready_i),
    .h_o(h_o), .h_valid_o(h_valid_o), .h_ready_o(h_ready_o),
    .done_o(done_o), .reject_hint(reject_hint)
  );

  task automatic do_reset(input logic [2:0] lvl);
    sec_lvl      = lvl;
    rst          = 1'b1;
    hint_valid_i = 1'b0;
    hint_i       = '0;
    h_ready_o    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clear_bytes();
    for (int i = 0; i < 88; i++) bb[i] = 8'd0;
  endtask

  task automatic send_words(input int nw);
    for (int n = 0; n < nw; n++) begin
      for (int b = 0; b < 8; b++) hint_i[8*b +: 8] = bb[8*n + b];
      hint_valid_i = 1'b1;
      @(posedge clk);
      #1;
    end
    hint_valid_i = 1'b0;
    hint_i       = '0;
  endtask

  task automatic collect(input int max_cyc);
    int tail;
    tail = -1;
    hq.delete();
    done_cnt  = 0;
    valid_cnt = 0;
    rej_seen  = 1'b0;
    h_ready_o = 1'b1;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      if (h_valid_o) begin
        valid_cnt++;
        hq.push_back(h_o);
      end
      if (done_o) done_cnt++;
      if (reject_hint) rej_seen = 1'b1;
      if (tail < 0 && (done_cnt > 0 || rej_seen)) tail = 4;
      @(posedge clk);
      #1;
      if (tail == 0) break;
      if (tail > 0) tail--;
    end
    h_ready_o = 1'b0;
  endtask

  task automatic load_lvl2_hints();
    clear_bytes();
    bb[0] = 8'd1; bb[1] = 8'd2; bb[2] = 8'd255;
    bb[80] = 8'd2; bb[81] = 8'd2; bb[82] = 8'd2; bb[83] = 8'd3;
  endtask

  task automatic test_reset();
    do_reset(3'd2);
    checks++; if (hint_ready_i !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", hint_ready_i); end
    checks++; if (h_valid_o !== 1'b0) begin errors++; $display("FAIL reset_hvalid got %0b exp 0", h_valid_o); end
    checks++; if (h_o !== 4'b0) begin errors++; $display("FAIL reset_h got %b exp 0000", h_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done_o); end
    checks++; if (reject_hint !== 1'b0) begin errors++; $display("FAIL reset_reject got %0b exp 0", reject_hint); end
  endtask

  task automatic test_zero();
    int nz;
    do_reset(3'd2);
    clear_bytes();
    send_words(11);
    checks++; if (h_valid_o !== 1'b0) begin errors++; $display("FAIL zero_check_cycle_hvalid got %0b exp 0", h_valid_o); end
    collect(400);
    nz = 0;
    foreach (hq[i]) if (hq[i] != 4'b0) nz++;
    checks++; if (hq.size() != 256) begin errors++; $display("FAIL zero_beats got %0d exp 256", hq.size()); end
    checks++; if (nz != 0) begin errors++; $display("FAIL zero_nonzero got %0d exp 0", nz); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done got %0d exp 1", done_cnt); end
    checks++; if (reject_hint !== 1'b0) begin errors++; $display("FAIL zero_reject got %0b exp 0", reject_hint); end
  endtask

  task automatic test_hints();
    int nz;
    do_reset(3'd2);
    load_lvl2_hints();
    send_words(11);
    collect(400);
    nz = 0;
    foreach (hq[i]) if (hq[i] != 4'b0) nz++;
    checks++; if (hq.size() != 256) begin errors++; $display("FAIL hints_beats got %0d exp 256", hq.size()); end
    if (hq.size() == 256) begin
      checks++; if (hq[0] !== 4'b0110) begin errors++; $display("FAIL hints_p0b0 got %b exp 0110", hq[0]); end
      checks++; if (hq[255] !== 4'b1000) begin errors++; $display("FAIL hints_p3b63 got %b exp 1000", hq[255]); end
    end
    checks++; if (nz != 2) begin errors++; $display("FAIL hints_nonzero got %0d exp 2", nz); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL hints_done got %0d exp 1", done_cnt); end
    checks++; if (reject_hint !== 1'b0) begin errors++; $display("FAIL hints_reject got %0b exp 0", reject_hint); end
  endtask

  task automatic test_order_reject();
    do_reset(3'd3);
    clear_bytes();
    bb[0] = 8'd5; bb[1] = 8'd5;
    for (int k = 0; k < 6; k++) bb[55 + k] = 8'd2;
    send_words(8);
    collect(200);
    checks++; if (!rej_seen) begin errors++; $display("FAIL order_reject got 0 exp 1"); end
    checks++; if (valid_cnt != 64) begin errors++; $display("FAIL order_beats got %0d exp 64", valid_cnt); end
    if (hq.size() > 1) begin
      checks++; if (hq[1] !== 4'b0010) begin errors++; $display("FAIL order_beat1 got %b exp 0010", hq[1]); end
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL order_done got %0d exp 0", done_cnt); end
    checks++; if (h_valid_o !== 1'b0) begin errors++; $display("FAIL order_hvalid_after got %0b exp 0", h_valid_o); end
  endtask

  task automatic test_check_reject();
    for (int t = 0; t < 3; t++) begin
      do_reset(3'd5);
      clear_bytes();
      case (t)
        0: begin
          bb[75] = 8'd3;
          for (int k = 1; k < 8; k++) bb[75 + k] = 8'd2;
        end
        1: bb[82] = 8'd76;
        default: begin
          bb[82] = 8'd1;
          bb[40] = 8'd7;
        end
      endcase
      send_words(11);
      collect(50);
      checks++; if (!rej_seen) begin errors++; $display("FAIL check_reject_%0d got 0 exp 1", t); end
      checks++; if (valid_cnt != 0) begin errors++; $display("FAIL check_hvalid_%0d got %0d beats exp 0", t, valid_cnt); end
      checks++; if (done_cnt != 0) begin errors++; $display("FAIL check_done_%0d got %0d exp 0", t, done_cnt); end
      checks++; if (hint_ready_i !== 1'b0) begin errors++; $display("FAIL check_ready_%0d got %0b exp 0", t, hint_ready_i); end
    end
  endtask

  task automatic test_stall();
    int unstable, bad_seq;
    bit stalled_prev;
    logic [3:0] prev_h, exp_h;
    do_reset(3'd2);
    load_lvl2_hints();
    send_words(11);
    hq.delete();
    done_cnt = 0; unstable = 0; bad_seq = 0; stalled_prev = 1'b0; prev_h = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      h_ready_o = 1'($urandom_range(0, 1));
      if (h_valid_o) begin
        if (stalled_prev && h_o !== prev_h) unstable++;
        if (h_ready_o) hq.push_back(h_o);
        stalled_prev = !h_ready_o;
        prev_h = h_o;
      end else begin
        stalled_prev = 1'b0;
      end
      if (done_o) done_cnt++;
      @(posedge clk);
      #1;
      if (done_cnt > 0) break;
      if (done_o) begin
        done_cnt++;
        break;
      end
    end
    h_ready_o = 1'b0;
    foreach (hq[i]) begin
      exp_h = (i == 0) ? 4'b0110 : ((i == 255) ? 4'b1000 : 4'b0000);
      if (hq[i] !== exp_h) bad_seq++;
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL stall_stable got %0d changes exp 0", unstable); end
    checks++; if (hq.size() != 256) begin errors++; $display("FAIL stall_beats got %0d exp 256", hq.size()); end
    checks++; if (bad_seq != 0) begin errors++; $display("FAIL stall_sequence got %0d wrong beats exp 0", bad_seq); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_rst_mid_emit();
    do_reset(3'd2);
    load_lvl2_hints();
    send_words(11);
    h_ready_o = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    h_ready_o = 1'b0;
    checks++; if (hint_ready_i !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %0b exp 1", hint_ready_i); end
    checks++; if (h_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_hvalid got %0b exp 0", h_valid_o); end
    checks++; if (h_o !== 4'b0) begin errors++; $display("FAIL rst_mid_h got %b exp 0000", h_o); end
    clear_bytes();
    send_words(10);
    checks++; if (hint_ready_i !== 1'b1 || h_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ctr ready=%0b hvalid=%0b exp ready=1 hvalid=0", hint_ready_i, h_valid_o);
    end
    send_words(1);
    @(posedge clk);
    #1;
    checks++; if (h_valid_o !== 1'b1) begin errors++; $display("FAIL rst_mid_reload_hvalid got %0b exp 1", h_valid_o); end
    collect(400);
    checks++; if (hq.size() != 256 || done_cnt != 1) begin
      errors++; $display("FAIL rst_mid_rerun beats=%0d done=%0d exp 256 and 1", hq.size(), done_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; sec_lvl = 3'd2; hint_i = '0; hint_valid_i = 1'b0; h_ready_o = 1'b0;
    test_reset();
    test_zero();
    test_hints();
    test_order_reject();
    test_check_reject();
    test_stall();
    test_rst_mid_emit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired exp bench to finish");
    $fatal(1, "watchdog");
  end

endmodule
